// File: rtl/race_pkg.sv
// Shared types and defaults for the two-lane drag-race tree sequencer.
package race_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StAmber,
      StGreen,
      StDone
   } race_state_e;

   localparam int unsigned LANE_LEFT  = 0;
   localparam int unsigned LANE_RIGHT = 1;

   localparam int unsigned DefaultNBits  = 16;
   localparam int unsigned DefaultNAmber = 3;

   // Width of the amber index register; at least one bit even for a single amber.
   function automatic int unsigned amber_idx_width(input int unsigned n_amber);
      return (n_amber > 1) ? $clog2(n_amber) : 1;
   endfunction

endpackage

// File: rtl/lane_reaction_counter.sv
// Per-lane foul detection, saturating reaction counter and result latch.
module lane_reaction_counter
   import race_pkg::*;
#(
   parameter int unsigned NBits = DefaultNBits
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             amber_i,
   input  logic             green_i,
   input  logic             go_i,
   output logic [NBits-1:0] react_o,
   output logic             foul_o,
   output logic             noshow_o,
   output logic             resolved_o
);

   localparam logic [NBits-1:0] CntMax = '1;

   logic [NBits-1:0] cnt_q, cnt_d, cnt_inc;
   logic             foul_q, foul_d;
   logic             noshow_q, noshow_d;
   logic             res_q, res_d;

   always_comb begin
      cnt_d    = cnt_q;
      foul_d   = foul_q;
      noshow_d = noshow_q;
      res_d    = res_q;
      cnt_inc  = cnt_q + NBits'(1);
      if (clear_i) begin
         cnt_d    = '0;
         foul_d   = 1'b0;
         noshow_d = 1'b0;
         res_d    = 1'b0;
      end else if (!res_q) begin
         if (amber_i && go_i) begin
            foul_d = 1'b1;
            res_d  = 1'b1;
            cnt_d  = CntMax;
         end else if (green_i) begin
            if (go_i) begin
               res_d = 1'b1;
            end else begin
               // Reaching the saturation value ends the lane as a no-show.
               cnt_d = cnt_inc;
               if (cnt_inc == CntMax) begin
                  noshow_d = 1'b1;
                  res_d    = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         foul_q   <= 1'b0;
         noshow_q <= 1'b0;
         res_q    <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         foul_q   <= foul_d;
         noshow_q <= noshow_d;
         res_q    <= res_d;
      end
   end

   assign react_o    = cnt_q;
   assign foul_o     = foul_q;
   assign noshow_o   = noshow_q;
   assign resolved_o = res_q;

endmodule

// File: rtl/race_tree_sequencer.sv
// Two-lane drag-race tree: amber countdown, false-start detection, reaction timing, winner.
// Define PRO_TREE_EN to collapse the ambers into one all-lit interval.
module race_tree_sequencer
   import race_pkg::*;
#(
   parameter int unsigned NBits  = DefaultNBits,
   parameter int unsigned NAmber = DefaultNAmber
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              tick_i,
   input  logic              left_go_i,
   input  logic              right_go_i,
   output logic              timer_reset_o,
   output logic              timer_enable_o,
   output logic [NAmber-1:0] amber_o,
   output logic              green_o,
   output logic              red_left_o,
   output logic              red_right_o,
   output logic              win_left_o,
   output logic              win_right_o,
   output logic [NBits-1:0]  react_left_o,
   output logic [NBits-1:0]  react_right_o,
   output logic              done_o
);

   localparam int unsigned      AmbW    = amber_idx_width(NAmber);
   localparam logic [AmbW-1:0]  AmbLast = AmbW'(NAmber - 1);

   race_state_e      state_q, state_d;
   logic [AmbW-1:0]  amb_q, amb_d;
   logic             win_l_q, win_l_d, win_r_q, win_r_d;
   logic             clear;
   logic             foul_l, foul_r, noshow_l, noshow_r, res_l, res_r;
   logic             clean_l, clean_r;

   assign clean_l = !foul_l && !noshow_l;
   assign clean_r = !foul_r && !noshow_r;

   always_comb begin
      state_d = state_q;
      amb_d   = amb_q;
      win_l_d = win_l_q;
      win_r_d = win_r_q;
      clear   = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d = StAmber;
               amb_d   = '0;
               win_l_d = 1'b0;
               win_r_d = 1'b0;
               clear   = 1'b1;
            end
         end
         StAmber: begin
            if (tick_i) begin
`ifdef PRO_TREE_EN
               state_d = StGreen;
`else
               if (amb_q == AmbLast) state_d = StGreen;
               else amb_d = amb_q + AmbW'(1);
`endif
            end
         end
         StGreen: begin
            if (res_l && res_r) begin
               state_d = StDone;
               // Two clean lanes race on count; otherwise only a clean lane can win.
               if (clean_l && clean_r) begin
                  win_l_d = (react_left_o <= react_right_o);
                  win_r_d = (react_right_o <= react_left_o);
               end else begin
                  win_l_d = clean_l;
                  win_r_d = clean_r;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         amb_q   <= '0;
         win_l_q <= 1'b0;
         win_r_q <= 1'b0;
      end else begin
         state_q <= state_d;
         amb_q   <= amb_d;
         win_l_q <= win_l_d;
         win_r_q <= win_r_d;
      end
   end

   always_comb begin
      timer_reset_o  = (state_q == StIdle) || (state_q == StDone);
      timer_enable_o = (state_q == StAmber);
      green_o        = (state_q == StGreen);
      done_o         = (state_q == StDone);
      amber_o        = '0;
      if (state_q == StAmber) begin
`ifdef PRO_TREE_EN
         amber_o = '1;
`else
         amber_o = NAmber'(1) << amb_q;
`endif
      end
   end

   assign win_left_o  = win_l_q;
   assign win_right_o = win_r_q;
   assign red_left_o  = foul_l;
   assign red_right_o = foul_r;

   lane_reaction_counter #(.NBits(NBits)) u_lane_left (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear),
      .amber_i    (state_q == StAmber),
      .green_i    (state_q == StGreen),
      .go_i       (left_go_i),
      .react_o    (react_left_o),
      .foul_o     (foul_l),
      .noshow_o   (noshow_l),
      .resolved_o (res_l)
   );

   lane_reaction_counter #(.NBits(NBits)) u_lane_right (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .clear_i    (clear),
      .amber_i    (state_q == StAmber),
      .green_i    (state_q == StGreen),
      .go_i       (right_go_i),
      .react_o    (react_right_o),
      .foul_o     (foul_r),
      .noshow_o   (noshow_r),
      .resolved_o (res_r)
   );

endmodule

// File: tb/tb_race_tree_sequencer.sv
// Bench for race_tree_sequencer: elapsed-time race model, per-cycle compare, directed + random races.
module tb_race_tree_sequencer;

   localparam int unsigned NB   = 8;
   localparam int unsigned NA   = 3;
   localparam int          MAXV = (1 << NB) - 1;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          start_i, tick_i, left_go_i, right_go_i;
   logic          timer_reset_o, timer_enable_o, green_o, done_o;
   logic [NA-1:0] amber_o;
   logic          red_left_o, red_right_o, win_left_o, win_right_o;
   logic [NB-1:0] react_left_o, react_right_o;

   always #5 clk_i = ~clk_i;

   race_tree_sequencer #(.NBits(NB), .NAmber(NA)) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .start_i        (start_i),
      .tick_i         (tick_i),
      .left_go_i      (left_go_i),
      .right_go_i     (right_go_i),
      .timer_reset_o  (timer_reset_o),
      .timer_enable_o (timer_enable_o),
      .amber_o        (amber_o),
      .green_o        (green_o),
      .red_left_o     (red_left_o),
      .red_right_o    (red_right_o),
      .win_left_o     (win_left_o),
      .win_right_o    (win_right_o),
      .react_left_o   (react_left_o),
      .react_right_o  (react_right_o),
      .done_o         (done_o)
   );

   int total = 0;
   int bad   = 0;

   // Model: phase 0 idle, 1 amber, 2 green, 3 done; m_el = cycles elapsed since green.
   int m_phase, m_amb, m_el;
   int m_react [2];
   bit m_foul [2], m_ns [2], m_res [2], m_win [2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_phase = 0; m_amb = 0; m_el = 0;
      for (int i = 0; i < 2; i++) begin
         m_react[i] = 0; m_foul[i] = 0; m_ns[i] = 0; m_res[i] = 0; m_win[i] = 0;
      end
   endfunction

   function automatic void model_step(input bit st, input bit tk, input bit gl, input bit gr);
      bit go [2];
      bit clean [2];
      go[0] = gl; go[1] = gr;
      case (m_phase)
         0, 3: if (st) begin
            model_reset();
            m_phase = 1;
         end
         1: begin
            for (int i = 0; i < 2; i++)
               if (!m_res[i] && go[i]) begin
                  m_foul[i] = 1; m_res[i] = 1; m_react[i] = MAXV;
               end
            if (tk) begin
`ifdef PRO_TREE_EN
               m_phase = 2;
`else
               if (m_amb == NA - 1) m_phase = 2;
               else m_amb++;
`endif
               m_el = 0;
            end
         end
         2: begin
            if (m_res[0] && m_res[1]) begin
               m_phase = 3;
               for (int i = 0; i < 2; i++) clean[i] = !m_foul[i] && !m_ns[i];
               if (clean[0] && clean[1]) begin
                  m_win[0] = m_react[0] <= m_react[1];
                  m_win[1] = m_react[1] <= m_react[0];
               end else begin
                  m_win[0] = clean[0];
                  m_win[1] = clean[1];
               end
            end else begin
               for (int i = 0; i < 2; i++)
                  if (!m_res[i]) begin
                     if (go[i]) begin
                        m_react[i] = m_el; m_res[i] = 1;
                     end else if (m_el + 1 == MAXV) begin
                        m_react[i] = MAXV; m_ns[i] = 1; m_res[i] = 1;
                     end
                  end
               m_el++;
            end
         end
         default: ;
      endcase
   endfunction

   task automatic check_all();
      logic [31:0] ea;
      ea = 0;
      if (m_phase == 1) begin
`ifdef PRO_TREE_EN
         ea = (1 << NA) - 1;
`else
         ea = 1 << m_amb;
`endif
      end
      chk("timer_reset", timer_reset_o, m_phase == 0 || m_phase == 3);
      chk("timer_enable", timer_enable_o, m_phase == 1);
      chk("green", green_o, m_phase == 2);
      chk("done", done_o, m_phase == 3);
      chk("amber", amber_o, ea);
      chk("red", {red_left_o, red_right_o}, {m_foul[0], m_foul[1]});
      chk("win", {win_left_o, win_right_o}, {m_win[0], m_win[1]});
      if (m_phase == 0 || m_phase == 3) begin
         chk("react_left", react_left_o, m_react[0]);
         chk("react_right", react_right_o, m_react[1]);
      end
   endtask

   task automatic step(input bit st, input bit tk, input bit gl, input bit gr);
      start_i = st; tick_i = tk; left_go_i = gl; right_go_i = gr;
      @(posedge clk_i);
      model_step(st, tk, gl, gr);
      @(negedge clk_i);
      check_all();
   endtask

   task automatic do_reset();
      start_i = 0; tick_i = 0; left_go_i = 0; right_go_i = 0;
      #2 rst_ni = 1'b0;
      model_reset();
      #1 check_all();
      @(posedge clk_i);
      @(negedge clk_i);
      check_all();
      chk("rst_amber_lit", amber_o, 0);
      chk("rst_timer_reset_lit", timer_reset_o, 1);
      #2 rst_ni = 1'b1;
      step(0, 0, 0, 0);
   endtask

   // f: -1 no foul, k pulse during amber k, 99 held from Start; g: green cycle of launch, -1 never.
   function automatic bit lane_go(input int f, input int g);
      if (f == 99) return 1'b1;
      if (m_phase == 1) return m_amb == f;
      if (m_phase == 2) return g >= 0 && m_el >= g;
      return 1'b0;
   endfunction

   task automatic run_race(input int gap, input int fl, input int fr, input int gl, input int gr,
                           input bit snoise, input int rst_at);
      bit st, tk;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         st = (cyc == 0) || (snoise && m_phase == 1 && m_amb == 1);
         tk = (cyc % gap) == gap - 1;
         if (rst_at >= 0 && m_phase == 2 && m_el == rst_at) begin
            do_reset();
            return;
         end
         step(st, tk, lane_go(fl, gl), lane_go(fr, gr));
         if (m_phase == 3) begin
            for (int k = 0; k < 4; k++)
               step(0, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            return;
         end
      end
      total++; bad++;
      $display("FAIL race_timeout: got no done expected done within 3000 cycles");
   endtask

   initial begin
      rst_ni = 1'b0;
      start_i = 0; tick_i = 0; left_go_i = 0; right_go_i = 0;
      model_reset();
      @(negedge clk_i);
      check_all();
      chk("reset_timer_reset_lit", timer_reset_o, 1);
      chk("reset_done_lit", done_o, 0);
      #2 rst_ni = 1'b1;

      // Hand-stepped race pinning the amber walk and a same-edge tie at zero.
`ifdef PRO_TREE_EN
      step(1, 0, 0, 0);
      chk("amber_all_lit", amber_o, 32'h7);
      step(0, 1, 0, 0);
`else
      step(1, 0, 0, 0);
      chk("amber0_lit", amber_o, 32'h1);
      step(0, 1, 0, 0);
      chk("amber1_lit", amber_o, 32'h2);
      step(1, 0, 0, 0);
      chk("start_ignored_lit", amber_o, 32'h2);
      step(0, 1, 0, 0);
      chk("amber2_lit", amber_o, 32'h4);
      step(0, 1, 0, 0);
`endif
      chk("green_lit", green_o, 1);
      for (int i = 0; i < 5 && m_phase != 3; i++) step(0, 0, 1, 1);
      chk("tie0_react_lit", {react_left_o, react_right_o}, 0);
      chk("tie0_win_lit", {win_left_o, win_right_o}, 2'b11);

      run_race(2, -1, -1, 5, 9, 0, -1);
      chk("r1_react_left_lit", react_left_o, 5);
      chk("r1_react_right_lit", react_right_o, 9);
      chk("r1_win_lit", {win_left_o, win_right_o}, 2'b10);
      chk("r1_done_lit", done_o, 1);

      run_race(1, -1, 1, 20, -1, 0, -1);
      chk("r2_react_left_lit", react_left_o, 20);
      chk("r2_react_right_lit", react_right_o, 255);
      chk("r2_red_lit", {red_left_o, red_right_o}, 2'b01);
      chk("r2_win_lit", {win_left_o, win_right_o}, 2'b10);

      run_race(3, -1, -1, 7, 7, 0, -1);
      chk("r3_react_lit", {react_left_o, react_right_o}, {8'd7, 8'd7});
      chk("r3_win_lit", {win_left_o, win_right_o}, 2'b11);

      run_race(1, -1, -1, 3, -1, 0, -1);
      chk("r4_react_right_sat_lit", react_right_o, 255);
      chk("r4_win_lit", {win_left_o, win_right_o}, 2'b10);

      run_race(2, 99, 99, -1, -1, 0, -1);
      chk("r5_red_lit", {red_left_o, red_right_o}, 2'b11);
      chk("r5_win_lit", {win_left_o, win_right_o}, 2'b00);

      run_race(2, 0, -1, -1, -1, 0, -1);
      chk("r6_win_lit", {win_left_o, win_right_o}, 2'b00);

      run_race(2, -1, -1, -1, -1, 0, 10);
      run_race(1, -1, -1, 12, 4, 1, -1);
      chk("r7_win_lit", {win_left_o, win_right_o}, 2'b01);

      for (int n = 0; n < 25; n++) begin
         int fl, fr, gl, gr, r;
         r  = $urandom_range(0, 9);
         fl = (r < 2) ? int'($urandom_range(0, NA - 1)) : (r == 2) ? 99 : -1;
         r  = $urandom_range(0, 9);
         fr = (r < 2) ? int'($urandom_range(0, NA - 1)) : (r == 2) ? 99 : -1;
         gl = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 40));
         gr = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 40));
         run_race(int'($urandom_range(1, 4)), fl, fr, gl, gr, 1'($urandom_range(0, 1)), -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
